pipeline_hex_display: RTL and testbench
=======================================

Name: pipeline_hex_display

Overview:
- Downstream consumer of the pipeline top's debug outputs, pc_out and register_out (the register selected by register_switch).
- Time-multiplexes a 4-digit common-anode seven-segment display showing 16 bits (low or high half) of either value.
- Two push-buttons, debounced on chip, toggle source (PC/register) and half (low/high).
- Value is snapshotted once per scan frame so all four digits are mutually consistent.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot; min 2.
- DEBOUNCE_CYCLES, 1000000: cycles a synchronised button level must be stable before acceptance; min 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pc_value  in  32  pipeline PC (pc_out).
- reg_value  in  32  selected register contents (register_out).
- btn_mode  in  1  raw asynchronous button; press toggles source.
- btn_half  in  1  raw asynchronous button; press toggles half.
- an  out  4  digit enables, active-low; an[i] drives digit i; digit 0 is rightmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- mode_o  out  1  0 = PC shown, 1 = register shown.
- half_o  out  1  0 = bits 15:0 shown, 1 = bits 31:16 shown.

Behaviour:
- Reset (asynchronous, while low), all outputs and state registered:
  - an=1111, seg=1111111, dp=1, mode_o=0, half_o=0.
  - Scan counter=0, digit index=0, snapshot=0.
  - Debouncers: synchronisers 0, accepted level 0, counters 0.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted for one cycle when the count equals SCAN_DIV-1.
- Digit index (2-bit):
  - Advances on tick: 0→1→2→3→0.
  - A frame is 4*SCAN_DIV cycles.
- Snapshot:
  - On tick with index==3, snapshot <= (mode_o ? reg_value : pc_value).
  - Input changes mid-frame are never shown mid-frame.
  - First frame after reset displays 0000.
- Display registers, updated only on tick, one cycle after the tick edge (nxt = index+1 mod 4):
  - an <= all ones except bit nxt = 0.
  - seg <= hex(nibble), where nibble = snapshot' bits [4*nxt+3+16*half_o : 4*nxt+16*half_o] and snapshot' is the newly loaded value on wrap, else the held snapshot.
  - dp <= 0 iff nxt==0 and half_o==1, else 1.
- Hex encoding, {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Debounce (per button):
  - Two-flop synchroniser, then a stability counter.
  - When the synchronised level differs from the accepted level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the accepted level flips and the counter clears.
  - A rising edge of the accepted level produces a one-cycle press pulse.
- mode_o toggles on a btn_mode press; half_o toggles on a btn_half press.
  - Both buttons act independently; simultaneous presses toggle both in the same cycle.
  - mode_o takes effect at the next snapshot; half_o takes effect at the next digit update.
  - The dp/half indicator is therefore immediate.
- Boundaries:
  - A press coincident with tick: toggle and display update both occur; the display uses the pre-toggle mode/half for that update.
  - Bounces shorter than DEBOUNCE_CYCLES are ignored.
  - Release needs no action beyond the debounce of the falling level.
  - Reset asserted mid-frame immediately blanks the display; scanning restarts at digit 0 after deassertion.

Decomposition:
- Shared package:
  - Hex-to-segment constant table (16 x 7).
  - Display mode encodings MODE_PC=0, MODE_REG=1.
  - Segment blank constant SEG_OFF=7'b1111111.
- Sub-module button_debouncer: synchroniser, stability counter, accepted level, press pulse; parameter DEBOUNCE_CYCLES. Instantiated twice.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- Reset low for 3 cycles, then high → an=1111, seg=1111111, dp=1, mode_o=0, half_o=0; first frame shows 0000 (seg=1000000 on each digit).
- pc_value=0x00401A3F held for two frames → second frame shows, in order:
  - an=1110 / seg=0001110
  - an=1101 / seg=0110000
  - an=1011 / seg=0001000
  - an=0111 / seg=1111001
  - dp=1 throughout.
- btn_mode toggles every cycle for 5 cycles, then stays high → mode_o goes 1 exactly 2+8 cycles after the last edge, once. With reg_value=0x0000BEEF, the following frame shows F,E,E,b.
- btn_mode pulses high for 6 cycles only → mode_o never changes.
- pc_value=0x00401A3F, btn_half pressed cleanly → half_o=1; digits 0..3 show 0,4,0,0 (1000000, 0011001, 1000000, 1000000); dp=0 only while an=1110.
- Reset asserted mid-frame with mode_o=1, half_o=1 → same cycle: an=1111, mode_o=0, half_o=0; after release, scanning restarts at digit 0 showing 0000.

Source files
------------

// File: rtl/pipeline_hex_display_pkg.sv
// Shared constants for the hex display: segment table, display source
// encodings and the blank-segment pattern.
package pipeline_hex_display_pkg;

  // Which pipeline value feeds the display snapshot.
  typedef enum logic {
    MODE_PC  = 1'b0,
    MODE_REG = 1'b1
  } mode_e;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex digit to {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Look up the segment pattern for one nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/pipeline_hex_display_if.sv
// Bundle of the pipeline debug inputs, button inputs and display outputs.
interface pipeline_hex_display_if;
  logic [31:0] pc_value;
  logic [31:0] reg_value;
  logic        btn_mode;
  logic        btn_half;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        mode_o;
  logic        half_o;

  // Side that supplies values and buttons and watches the display.
  modport master (
    output pc_value, reg_value, btn_mode, btn_half,
    input  an, seg, dp, mode_o, half_o
  );

  // Display controller side.
  modport slave (
    input  pc_value, reg_value, btn_mode, btn_half,
    output an, seg, dp, mode_o, half_o
  );
endinterface

// File: rtl/pipeline_hex_display_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability counter,
// accepted level and a one-cycle press strobe on the accepted rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip_s;

  // Next-state: count while the synchronised level disagrees, accept on expiry.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    flip_s  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        flip_s  = 1'b1;
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    // Strobe coincides with acceptance so the toggle lands on the same edge.
    press_o = flip_s & ~level_q;
  end

  // Synchroniser, accepted level and stability counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_hex_display.sv
// Four-digit multiplexed hex display of the pipeline PC or selected register.
// A per-frame snapshot keeps all four digits coherent; two debounced buttons
// pick the source and which 16-bit half is shown.
module pipeline_hex_display
  import pipeline_hex_display_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_hex_display_if.slave bus
);

  localparam int               SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       snap_q, snap_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  mode_e             mode_q, mode_d;
  logic              half_q, half_d;

  logic              tick_s;
  logic [1:0]        nxt_s;
  logic [31:0]       snap_view_s;
  logic [4:0]        shamt_s;
  logic              mode_press_s;
  logic              half_press_s;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (bus.btn_mode),
    .press_o (mode_press_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_half (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (bus.btn_half),
    .press_o (half_press_s)
  );

  // Scan timing, frame snapshot, digit decode and button toggles.
  always_comb begin
    tick_s      = (scan_cnt_q == SCAN_LAST);
    nxt_s       = idx_q + 2'd1;
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    snap_view_s = snap_q;
    an_d        = an_q;
    seg_d       = seg_q;
    dp_d        = dp_q;
    // Bit offset of the nibble: 16*half + 4*digit.
    shamt_s     = {half_q, nxt_s, 2'b00};
    if (tick_s) begin
      scan_cnt_d = '0;
      idx_d      = nxt_s;
      // Wrapping to digit 0 starts a new frame: load and show the fresh value.
      if (idx_q == 2'd3) begin
        snap_d      = (mode_q == MODE_REG) ? bus.reg_value : bus.pc_value;
        snap_view_s = snap_d;
      end else begin
        snap_view_s = snap_q;
      end
      an_d  = ~(4'b0001 << nxt_s);
      seg_d = hex_to_seg(4'(snap_view_s >> shamt_s));
      dp_d  = ~((nxt_s == 2'd0) & half_q);
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end
    // Decisions above used the pre-toggle mode/half.
    mode_d = mode_e'(mode_q ^ mode_press_s);
    half_d = half_q ^ half_press_s;
  end

  // Display and control state; reset blanks the display immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      snap_q     <= 32'd0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      mode_q     <= MODE_PC;
      half_q     <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      mode_q     <= mode_d;
      half_q     <= half_d;
    end
  end

  assign bus.an     = an_q;
  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.mode_o = mode_q;
  assign bus.half_o = half_q;

endmodule

// File: tb/tb_pipeline_hex_display.sv
// Directed bench for pipeline_hex_display with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_pipeline_hex_display;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_hex_display_if bus ();

  pipeline_hex_display #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wait (bounded) for the next time digit 'tgt' becomes active, then check it.
  task automatic wait_an(input string tag, input logic [3:0] tgt,
                         input logic [6:0] seg_exp, input logic dp_exp);
    int n;
    n = 0;
    while (bus.an == tgt && n < 64) begin @(negedge clock); n++; end
    while (bus.an != tgt && n < 64) begin @(negedge clock); n++; end
    chk({tag, "_an"}, 32'(bus.an), 32'(tgt));
    chk({tag, "_seg"}, 32'(bus.seg), 32'(seg_exp));
    chk({tag, "_dp"}, 32'(bus.dp), 32'(dp_exp));
  endtask

  // Hold a button level long enough to be accepted both ways.
  task automatic clean_press(input bit which_half);
    if (which_half) bus.btn_half = 1'b1; else bus.btn_mode = 1'b1;
    cyc(12);
    if (which_half) bus.btn_half = 1'b0; else bus.btn_mode = 1'b0;
    cyc(12);
  endtask

  initial begin
    logic flag;
    bus.pc_value  = 32'd0;
    bus.reg_value = 32'd0;
    bus.btn_mode  = 1'b0;
    bus.btn_half  = 1'b0;

    // Reset state.
    cyc(3);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_mode", 32'(bus.mode_o), 32'd0);
    chk("rst_half", 32'(bus.half_o), 32'd0);
    reset = 1'b1;

    // First frame shows 0000.
    wait_an("f0_d1", 4'b1101, 7'b1000000, 1'b1);
    wait_an("f0_d2", 4'b1011, 7'b1000000, 1'b1);
    wait_an("f0_d3", 4'b0111, 7'b1000000, 1'b1);
    wait_an("f0_d0", 4'b1110, 7'b1000000, 1'b1);

    // PC value 0x00401A3F, low half.
    bus.pc_value = 32'h00401A3F;
    wait_an("pc_d0", 4'b1110, 7'b0001110, 1'b1);
    wait_an("pc_d1", 4'b1101, 7'b0110000, 1'b1);
    wait_an("pc_d2", 4'b1011, 7'b0001000, 1'b1);
    wait_an("pc_d3", 4'b0111, 7'b1111001, 1'b1);

    // Bouncing mode button, then steady high: accepted exactly 10 cycles later.
    bus.reg_value = 32'h0000BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.btn_mode = (i % 2 == 0);
    end
    flag = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (bus.mode_o !== 1'b0) flag = 1'b1;
    end
    chk("mode_early", 32'(flag), 32'd0);
    @(negedge clock);
    chk("mode_at10", 32'(bus.mode_o), 32'd1);
    cyc(5);
    chk("mode_once", 32'(bus.mode_o), 32'd1);
    wait_an("reg_d0", 4'b1110, 7'b0001110, 1'b1);
    wait_an("reg_d1", 4'b1101, 7'b0000110, 1'b1);
    wait_an("reg_d2", 4'b1011, 7'b0000110, 1'b1);
    wait_an("reg_d3", 4'b0111, 7'b0000011, 1'b1);

    // Release is not a press.
    bus.btn_mode = 1'b0;
    cyc(14);
    chk("release_mode", 32'(bus.mode_o), 32'd1);

    // Six-cycle glitch is rejected.
    bus.btn_mode = 1'b1;
    cyc(6);
    bus.btn_mode = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.mode_o !== 1'b1) flag = 1'b1;
    end
    chk("glitch_mode", 32'(flag), 32'd0);

    // Back to PC, then select the high half.
    clean_press(1'b0);
    chk("mode_back", 32'(bus.mode_o), 32'd0);
    clean_press(1'b1);
    chk("half_set", 32'(bus.half_o), 32'd1);
    wait_an("hi_d0", 4'b1110, 7'b1000000, 1'b0);
    wait_an("hi_d1", 4'b1101, 7'b0011001, 1'b1);
    wait_an("hi_d2", 4'b1011, 7'b1000000, 1'b1);
    wait_an("hi_d3", 4'b0111, 7'b1000000, 1'b1);

    // Mid-frame reset with mode=1, half=1.
    clean_press(1'b0);
    chk("mode_pre_rst", 32'(bus.mode_o), 32'd1);
    wait_an("pre_rst", 4'b1011, 7'b1000000, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mrst_an", 32'(bus.an), 32'hF);
    chk("mrst_seg", 32'(bus.seg), 32'h7F);
    chk("mrst_dp", 32'(bus.dp), 32'd1);
    chk("mrst_mode", 32'(bus.mode_o), 32'd0);
    chk("mrst_half", 32'(bus.half_o), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    chk("restart_blank", 32'(bus.an), 32'hF);
    @(negedge clock);
    chk("restart_an", 32'(bus.an), 32'hD);
    chk("restart_seg", 32'(bus.seg), 32'h40);
    wait_an("rs_d2", 4'b1011, 7'b1000000, 1'b1);
    wait_an("rs_d3", 4'b0111, 7'b1000000, 1'b1);
    wait_an("rs_d0", 4'b1110, 7'b0001110, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
